// File: rtl/prll_bs_drvr_endpoint.sv
// rtl/prll_bs_drvr_endpoint.sv - driver-side bus endpoint: TX FIFO drained by arbiter, ID-filtered RX FIFO
// Contains the shared first-word-fall-through FIFO and the endpoint top.

module prll_bs_drvr_endpoint_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] head,
  output logic             not_empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_rd;
  logic             do_wr;

  // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
  assign do_rd     = rd_en && (count != '0);
  assign do_wr     = wr_en && ((count != FULL_CNT) || do_rd);
  assign not_empty = (count != '0);
  assign full      = (count == FULL_CNT);
  assign head      = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_wr && !do_rd) begin
        count <= count + CW'(1);
      end else if (do_rd && !do_wr) begin
        count <= count - CW'(1);
      end
      if (wr_en && !do_wr) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

module prll_bs_drvr_endpoint #(
  parameter int         bits      = 32,
  parameter int         depth     = 8,
  parameter logic [7:0] id        = 8'd0,
  parameter logic [7:0] broadcast = 8'hFF,
  localparam int        CW        = $clog2(depth + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_push,
  input  logic [bits-1:0] tx_data,
  output logic            tx_full,
  output logic [CW-1:0]   tx_count,
  output logic            tx_ovf,
  output logic            pndng,
  output logic [bits-1:0] D_pop,
  input  logic            pop,
  input  logic            push,
  input  logic [bits-1:0] D_push,
  output logic            rx_pndng,
  output logic [bits-1:0] rx_data,
  input  logic            rx_pop,
  output logic [CW-1:0]   rx_count,
  output logic            rx_ovf,
  output logic [15:0]     rx_filt_cnt
);

  logic [7:0] rx_dest;
  logic       rx_accept;
  logic       rx_full;

  assign rx_dest   = D_push[bits-1:bits-8];
  assign rx_accept = push && ((rx_dest == id) || (rx_dest == broadcast));

  prll_bs_drvr_endpoint_fifo #(
    .WIDTH (bits),
    .DEPTH (depth),
    .CW    (CW)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (tx_push),
    .wr_data   (tx_data),
    .rd_en     (pop),
    .head      (D_pop),
    .not_empty (pndng),
    .full      (tx_full),
    .count     (tx_count),
    .ovf       (tx_ovf)
  );

  prll_bs_drvr_endpoint_fifo #(
    .WIDTH (bits),
    .DEPTH (depth),
    .CW    (CW)
  ) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (rx_accept),
    .wr_data   (D_push),
    .rd_en     (rx_pop),
    .head      (rx_data),
    .not_empty (rx_pndng),
    .full      (rx_full),
    .count     (rx_count),
    .ovf       (rx_ovf)
  );

  // Filter drops are counted, not stored; the counter sticks at its maximum.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_filt_cnt <= '0;
    end else if (push && !rx_accept && (rx_filt_cnt != 16'hFFFF)) begin
      rx_filt_cnt <= rx_filt_cnt + 16'd1;
    end
  end

endmodule
